// File: rtl/config_loader.sv
// config_loader: bit-serial loader that deserializes address/data frames and
// issues one-cycle config_en strobes with a shared 32-bit config_data word.
module config_loader #(
  parameter int NUM_TILES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cfg_bit_in,
  input  logic                 cfg_bit_valid,
  output logic                 cfg_bit_ready,
  output logic [31:0]          config_data,
  output logic [NUM_TILES-1:0] config_en,
  output logic                 busy,
  output logic                 done,
  output logic                 addr_err,
  output logic [15:0]          words_written
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] END_MARK = 8'hFF;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] shift_q, shift_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [15:0] words_q, words_d;

  logic bit_xfer;
  logic in_range;

  // Handshake and status flags decode straight from the state register.
  always_comb begin
    cfg_bit_ready = (state_q == S_ADDR) || (state_q == S_DATA);
    busy          = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_WRITE);
    done          = (state_q == S_DONE);
    bit_xfer      = cfg_bit_valid && cfg_bit_ready;
    in_range      = int'(addr_q) < NUM_TILES;
  end

  // One-hot strobe only in WRITE; an out-of-range address matches no bit.
  always_comb begin
    config_en = '0;
    for (int i = 0; i < NUM_TILES; i++)
      config_en[i] = (state_q == S_WRITE) && (addr_q == 8'(i));
  end

  // Next-state, shift registers, counters and status.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    words_d = words_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_ADDR;
          cnt_d   = '0;
          err_d   = 1'b0;
          words_d = '0;
        end
      end
      S_ADDR: begin
        if (bit_xfer) begin
          addr_d = {addr_q[6:0], cfg_bit_in};
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == 6'd7) begin
            cnt_d   = '0;
            state_d = (addr_d == END_MARK) ? S_DONE : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (bit_xfer) begin
          shift_d = {shift_q[30:0], cfg_bit_in};
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            // The bus takes the fresh word as WRITE begins, so the strobe sees it.
            data_d  = shift_d;
            cnt_d   = '0;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (in_range) begin
          if (words_q != 16'hFFFF) words_d = words_q + 16'd1;
        end else begin
          err_d = 1'b1;
        end
        cnt_d   = '0;
        state_d = S_ADDR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      words_q <= words_d;
    end
  end

  assign config_data   = data_q;
  assign addr_err      = err_q;
  assign words_written = words_q;

endmodule
